// File: rtl/nuc970_ecc_pkg.sv
// Shared types and helpers for the nuc970 BCH encoder page sequencer.
package nuc970_ecc_pkg;

  localparam int M = 13;

  typedef enum logic [1:0] {IDLE, WAIT, FEED, DRAIN} sched_state_e;

  function automatic int ecc_bytes(input int m, input int t);
    return (m * t + 7) / 8;
  endfunction

endpackage

// File: rtl/nuc970_ecc_sched.sv
// nuc970_ecc_sched: feeds a NAND page to the shared BCH encoder one sector at a time and re-emits tagged parity.
// Optional feature NUC970_ECC_SCHED_ERASED_EN adds sector_erased and forces ECC of all-0xFF sectors to 8'hFF.
module nuc970_ecc_sched
  import nuc970_ecc_pkg::*;
#(
  parameter int T          = 4,
  parameter int DATA_BYTES = 536,
  parameter int ECC_BYTES  = ecc_bytes(M, T),
  parameter int SECTORS    = 4,
  localparam int SW        = (SECTORS > 1) ? $clog2(SECTORS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          page_start,
  output logic          page_busy,
  output logic          page_done,
  input  logic [7:0]    s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [7:0]    enc_data,
  output logic          enc_start,
  output logic          enc_ce,
  input  logic          enc_ready,
  input  logic          enc_ecc_bits,
  input  logic [7:0]    enc_out,
  input  logic          enc_last,
  output logic [7:0]    ecc_data,
  output logic          ecc_valid,
  output logic [SW-1:0] ecc_sector,
  output logic          ecc_last,
`ifdef NUC970_ECC_SCHED_ERASED_EN
  output logic          sector_erased,
`endif
  output logic          err_overrun
);

  localparam int BW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam int CW = $clog2(ECC_BYTES + 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(DATA_BYTES - 1);
  localparam logic [CW-1:0] ECC_FULL  = CW'(ECC_BYTES);
  localparam logic [CW-1:0] ECC_FINAL = CW'(ECC_BYTES - 1);
  localparam logic [SW-1:0] LAST_SEC  = SW'(SECTORS - 1);

  sched_state_e  state_q, state_d;
  logic [SW-1:0] sector_q, sector_d;
  logic [BW-1:0] byte_cnt_q, byte_cnt_d;
  logic [CW-1:0] ecc_cnt_q, ecc_cnt_d, ecc_cnt_inc;
  logic          busy_q, busy_d;
  logic          done_pend_q, done_pend_d;
  logic          page_done_q, page_done_d;
  logic          err_q, err_d;
  logic [7:0]    ecc_data_q, ecc_data_d;
  logic          ecc_valid_q, ecc_valid_d;
  logic [SW-1:0] ecc_sector_q, ecc_sector_d;
  logic          ecc_last_q, ecc_last_d;
`ifdef NUC970_ECC_SCHED_ERASED_EN
  logic          erased_q, erased_d;
  logic          sector_erased_q, sector_erased_d;
`endif

  always_comb begin
    state_d      = state_q;
    sector_d     = sector_q;
    byte_cnt_d   = byte_cnt_q;
    ecc_cnt_d    = ecc_cnt_q;
    busy_d       = busy_q;
    done_pend_d  = 1'b0;
    page_done_d  = done_pend_q;
    err_d        = err_q;
    ecc_data_d   = ecc_data_q;
    ecc_valid_d  = 1'b0;
    ecc_sector_d = ecc_sector_q;
    ecc_last_d   = 1'b0;
    ecc_cnt_inc  = ecc_cnt_q + CW'(enc_ecc_bits);
    s_ready      = 1'b0;
    enc_ce       = 1'b0;
    enc_start    = 1'b0;
    enc_data     = '0;
`ifdef NUC970_ECC_SCHED_ERASED_EN
    erased_d        = erased_q;
    sector_erased_d = 1'b0;
`endif
    // busy drops together with the page_done pulse, so a new page cannot overlap the tail
    if (done_pend_q) busy_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (page_start && !busy_q) begin
          busy_d     = 1'b1;
          err_d      = 1'b0;
          sector_d   = '0;
          byte_cnt_d = '0;
          ecc_cnt_d  = '0;
          state_d    = enc_ready ? FEED : WAIT;
        end
      end
      WAIT: begin
        if (enc_ready) state_d = FEED;
      end
      FEED: begin
        s_ready   = 1'b1;
        enc_ce    = s_valid;
        enc_data  = s_data;
        enc_start = s_valid && (byte_cnt_q == '0);
        if (s_valid) begin
`ifdef NUC970_ECC_SCHED_ERASED_EN
          erased_d = ((byte_cnt_q == '0) ? 1'b1 : erased_q) & (&s_data);
`endif
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_d = '0;
            ecc_cnt_d  = '0;
            state_d    = DRAIN;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        enc_ce = 1'b1;
        if (enc_ecc_bits) begin
          ecc_valid_d  = 1'b1;
          ecc_sector_d = sector_q;
          ecc_last_d   = (ecc_cnt_q == ECC_FINAL);
          ecc_cnt_d    = ecc_cnt_inc;
`ifdef NUC970_ECC_SCHED_ERASED_EN
          ecc_data_d      = erased_q ? 8'hFF : enc_out;
          sector_erased_d = erased_q;
`else
          ecc_data_d = enc_out;
`endif
        end
        // A byte arriving with enc_last is captured above before the sector advances
        if (enc_last || (ecc_cnt_inc == ECC_FULL)) begin
          if (ecc_cnt_inc != ECC_FULL) err_d = 1'b1;
          ecc_cnt_d = '0;
          if (sector_q != LAST_SEC) begin
            sector_d = sector_q + 1'b1;
            state_d  = WAIT;
          end else begin
            done_pend_d = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      sector_q     <= '0;
      byte_cnt_q   <= '0;
      ecc_cnt_q    <= '0;
      busy_q       <= 1'b0;
      done_pend_q  <= 1'b0;
      page_done_q  <= 1'b0;
      err_q        <= 1'b0;
      ecc_data_q   <= '0;
      ecc_valid_q  <= 1'b0;
      ecc_sector_q <= '0;
      ecc_last_q   <= 1'b0;
`ifdef NUC970_ECC_SCHED_ERASED_EN
      erased_q        <= 1'b0;
      sector_erased_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sector_q     <= sector_d;
      byte_cnt_q   <= byte_cnt_d;
      ecc_cnt_q    <= ecc_cnt_d;
      busy_q       <= busy_d;
      done_pend_q  <= done_pend_d;
      page_done_q  <= page_done_d;
      err_q        <= err_d;
      ecc_data_q   <= ecc_data_d;
      ecc_valid_q  <= ecc_valid_d;
      ecc_sector_q <= ecc_sector_d;
      ecc_last_q   <= ecc_last_d;
`ifdef NUC970_ECC_SCHED_ERASED_EN
      erased_q        <= erased_d;
      sector_erased_q <= sector_erased_d;
`endif
    end
  end

  assign page_busy   = busy_q;
  assign page_done   = page_done_q;
  assign ecc_data    = ecc_data_q;
  assign ecc_valid   = ecc_valid_q;
  assign ecc_sector  = ecc_sector_q;
  assign ecc_last    = ecc_last_q;
  assign err_overrun = err_q;
`ifdef NUC970_ECC_SCHED_ERASED_EN
  assign sector_erased = sector_erased_q;
`endif

endmodule

// File: doc/nuc970_ecc_sched.md
Name: nuc970_ecc_sched

Overview:
- Page-level sequencer for the shared nuc970_encode BCH encoder (byte-wide, BITS=8).
- Takes a NAND page of SECTORS sectors as a valid/ready byte stream and feeds the encoder one sector at a time: start pulse, clock-enable gating on source stalls, drain of parity.
- Re-emits each sector's ECC bytes tagged with the sector index.
- Sits between the NAND write DMA and the encoder; the encoder is instantiated by the parent with PIPELINE_STAGES=0.

Parameters:
- T, 4, correction capability passed through to the encoder.
- DATA_BYTES, 536, bytes per sector (encoder DATA_BITS/8).
- ECC_BYTES, 7, parity bytes per sector, ceil(13*T/8).
- SECTORS, 4, sectors per page; must be >= 1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- page_start  in  1  one-cycle pulse to begin a page; ignored while page_busy.
- page_busy  out  1  high from the cycle after an accepted page_start until page_done.
- page_done  out  1  one-cycle pulse after the last ECC byte of the last sector.
- s_data  in  8  source byte.
- s_valid  in  1  source byte valid.
- s_ready  out  1  byte accepted when s_valid&&s_ready.
- enc_data  out  8  to encoder data_in.
- enc_start  out  1  to encoder start.
- enc_ce  out  1  to encoder ce.
- enc_ready  in  1  from encoder ready.
- enc_ecc_bits  in  1  from encoder ecc_bits.
- enc_out  in  8  from encoder data_out.
- enc_last  in  1  from encoder last.
- ecc_data  out  8  parity byte.
- ecc_valid  out  1  parity byte strobe; no backpressure.
- ecc_sector  out  $clog2(SECTORS)  sector index of ecc_data.
- ecc_last  out  1  marks the final parity byte of a sector.
- err_overrun  out  1  sticky; encoder signalled enc_last before ECC_BYTES were captured. Cleared by reset or by an accepted page_start.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0.
- IDLE
  - page_start && enc_ready → FEED, sector=0, byte_cnt=0.
  - page_start && !enc_ready → WAIT.
- WAIT: enc_ready → FEED.
- FEED
  - s_ready = 1; enc_ce = s_valid; enc_data = s_data (combinational pass-through, zero latency).
  - enc_start = s_valid && byte_cnt==0.
  - Each accepted byte increments byte_cnt.
  - Source stall (s_valid=0): enc_ce=0, so encoder state is frozen and no byte is lost.
  - Byte DATA_BYTES-1 accepted → DRAIN, byte_cnt=0.
- DRAIN
  - s_ready = 0; enc_ce = 1; enc_start = 0.
  - On each enc_ecc_bits: register enc_out → ecc_data with ecc_valid=1 next cycle, ecc_sector=sector, and ecc_cnt++.
  - ecc_last is asserted on the byte where ecc_cnt==ECC_BYTES-1.
  - Exit condition: the cycle enc_last is seen or ecc_cnt reaches ECC_BYTES.
    - If sector<SECTORS-1: sector++ and go to WAIT (enc_ready is re-checked before the next start).
    - Otherwise: page_done pulses one cycle later and state returns to IDLE.
  - enc_last before ECC_BYTES captured: set err_overrun, still advance.
- Simultaneous enc_last and final enc_ecc_bits: the byte is captured, then the FSM advances.
- page_start in any non-IDLE state: ignored, no effect.
- Reset mid-page: immediate return to IDLE, outputs cleared. The encoder is re-synchronised by the next enc_start.
- SECTORS=1: ecc_sector width is forced to 1 bit, tied 0.

Optional Feature:
- NUC970_ECC_SCHED_ERASED_EN
  - Defined:
    - Per-sector AND-reduction of accepted data bytes.
    - Output sector_erased (1 bit) is valid alongside ecc_last: 1 if every data byte was 8'hFF.
    - In that case the emitted ECC bytes are forced to 8'hFF (NAND erased-page convention).
  - Undefined: port absent, ECC passed unmodified.

Decomposition:
- Package nuc970_ecc_pkg holds:
  - FSM state enum (IDLE, WAIT, FEED, DRAIN).
  - Function ecc_bytes(m,t) = (m*t+7)/8.
  - Localparam M=13.
- No sub-module. Counters and FSM stay in one file; the encoder is instantiated by the parent, not in this block.

Test Plan:
1. SECTORS=1, 536 bytes of 8'hFF streamed back-to-back, behavioural encoder → exactly 7 ecc_valid pulses, ecc_last on the 7th, page_done 1 cycle after, total latency equal to the standalone encoder run.
2. Same data with s_valid toggling 1-0 every cycle → identical ECC bytes to scenario 1; enc_ce low on every stalled cycle; enc_start exactly once.
3. SECTORS=4, distinct ramp data per sector → ecc_sector 0,1,2,3 in order; 28 ecc_valid total; page_busy high throughout; page_done once.
4. Reset asserted at byte 300 of sector 2, then a new page_start → all outputs 0 during reset; new page begins at sector 0 with correct ECC.
5. page_start pulsed during DRAIN → ignored; enc_ready held low 5 cycles before sector 1 → FSM waits in WAIT, enc_start asserted only after enc_ready rises.
6. Encoder model asserting enc_last after 5 ECC bytes → err_overrun=1, FSM advances to the next sector; ERASED_EN build with all-0xFF sector → sector_erased=1, ECC bytes 8'hFF.
